wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order pipeline write-back (the WB stage mux result) and a long-latency result source such as a multiply/divide unit.
- Pipeline writes have priority. Long-latency results are buffered in a small FIFO and drained into idle write-port slots.
- A starvation counter forces a one-cycle pipeline stall so buffered results always drain.
- Sits between the WB stage and the register file; also drives a scoreboard query for the hazard unit.

---
 rtl/wb_arb_pkg.sv | 23 ++
 rtl/wb_port_arbiter_if.sv | 34 +++
 rtl/wb_result_fifo.sv | 62 ++++++
 rtl/wb_port_arbiter.sv | 129 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
package wb_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        FORCE   = 2'd2
    } wb_arb_state_t;

    // $0 is hardwired, so a write there is never a real write.
    function automatic logic is_live(input logic [REG_ADDR_W-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Write-back / MDU / register-file / hazard-query signal bundle for wb_port_arbiter.
interface wb_port_arbiter_if #(
    parameter int PTR_W = 2
);
    logic                              WB_RegWrite;
    logic [wb_arb_pkg::REG_ADDR_W-1:0] WB_WriteReg;
    logic [wb_arb_pkg::DATA_W-1:0]     WB_WriteData;
    logic                              MDU_Valid;
    logic                              MDU_Ready;
    logic [wb_arb_pkg::REG_ADDR_W-1:0] MDU_WriteReg;
    logic [wb_arb_pkg::DATA_W-1:0]     MDU_WriteData;
    logic                              RF_RegWrite;
    logic [wb_arb_pkg::REG_ADDR_W-1:0] RF_WriteReg;
    logic [wb_arb_pkg::DATA_W-1:0]     RF_WriteData;
    logic                              WB_Stall;
    logic [PTR_W:0]                    Pending_Count;
    logic [wb_arb_pkg::REG_ADDR_W-1:0] Query_Reg;
    logic                              Query_Hit;

    modport master (
        output WB_RegWrite, WB_WriteReg, WB_WriteData,
        output MDU_Valid, MDU_WriteReg, MDU_WriteData, Query_Reg,
        input  MDU_Ready, RF_RegWrite, RF_WriteReg, RF_WriteData,
        input  WB_Stall, Pending_Count, Query_Hit
    );

    modport slave (
        input  WB_RegWrite, WB_WriteReg, WB_WriteData,
        input  MDU_Valid, MDU_WriteReg, MDU_WriteData, Query_Reg,
        output MDU_Ready, RF_RegWrite, RF_WriteReg, RF_WriteData,
        output WB_Stall, Pending_Count, Query_Hit
    );

endinterface

// File: rtl/wb_result_fifo.sv
// Small in-order FIFO of pending long-latency results with a parallel
// destination-register match for the hazard unit.
module wb_result_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  wb_req_t               i_req,
    output wb_req_t               o_head,
    output logic [PTR_W:0]        o_count,
    input  logic [REG_ADDR_W-1:0] i_query_reg,
    output logic                  o_query_hit
);

    wb_req_t          r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [DEPTH-1:0] w_match;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else begin
            if (i_pop) begin
                r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
                r_vld[r_rd_ptr] <= 1'b0;
            end
            if (i_push) begin
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
                r_vld[r_wr_ptr] <= 1'b1;
            end
            if (i_push && !i_pop)
                r_count <= r_count + (PTR_W+1)'(1);
            else if (!i_push && i_pop)
                r_count <= r_count - (PTR_W+1)'(1);
        end
    end

    // Payload needs no reset: r_vld qualifies every use of it.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_req;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        assign w_match[g] = r_vld[g] && (r_mem[g].rd == i_query_reg);
    end

    assign o_head      = r_mem[r_rd_ptr];
    assign o_count     = r_count;
    assign o_query_hit = is_live(i_query_reg) && (|w_match);

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back wins, buffered MDU results
// fill idle slots, starvation forces a one-cycle stall. Optional: WB_ARB_BYPASS_EN.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int PTR_W        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    wb_port_arbiter_if.slave bus
);

    localparam int             SC_W       = $clog2(STARVE_LIMIT);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT - 1);
    localparam logic [PTR_W:0]  FULL       = (PTR_W+1)'(DEPTH);

    wb_arb_state_t        r_state, w_state_nxt;
    logic [SC_W-1:0]      r_starve, w_starve_nxt;
    logic [PTR_W:0]       w_count, w_count_nxt;
    wb_req_t              w_head, w_mdu_req;
    logic                 w_pipe_wr, w_ready, w_push, w_enq, w_pop, w_bypass;
    logic                 w_rf_we, w_stall;
    logic [REG_ADDR_W-1:0] w_rf_reg;
    logic [DATA_W-1:0]    w_rf_data;

    assign w_pipe_wr = bus.WB_RegWrite && is_live(bus.WB_WriteReg);
    assign w_ready   = (w_count < FULL);
    assign w_push    = bus.MDU_Valid && w_ready;
    assign w_mdu_req = '{rd: bus.MDU_WriteReg, data: bus.MDU_WriteData};

`ifdef WB_ARB_BYPASS_EN
    assign w_bypass = w_push && (w_count == '0) && (r_state != FORCE) && !w_pipe_wr
                      && is_live(bus.MDU_WriteReg);
`else
    assign w_bypass = 1'b0;
`endif

    // $0 results complete the handshake but never occupy a slot.
    assign w_enq = w_push && is_live(bus.MDU_WriteReg) && !w_bypass;

    wb_result_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .i_clk       (Clock),
        .i_rst       (Reset),
        .i_push      (w_enq),
        .i_pop       (w_pop),
        .i_req       (w_mdu_req),
        .o_head      (w_head),
        .o_count     (w_count),
        .i_query_reg (bus.Query_Reg),
        .o_query_hit (bus.Query_Hit)
    );

    always_comb begin
        w_rf_we   = 1'b0;
        w_rf_reg  = '0;
        w_rf_data = '0;
        w_stall   = 1'b0;
        w_pop     = 1'b0;
        if (!Reset) begin
            if (r_state == FORCE) begin
                w_stall   = 1'b1;
                w_pop     = 1'b1;
                w_rf_we   = 1'b1;
                w_rf_reg  = w_head.rd;
                w_rf_data = w_head.data;
            end else if (w_pipe_wr) begin
                w_rf_we   = 1'b1;
                w_rf_reg  = bus.WB_WriteReg;
                w_rf_data = bus.WB_WriteData;
            end else if (w_count != '0) begin
                w_pop     = 1'b1;
                w_rf_we   = 1'b1;
                w_rf_reg  = w_head.rd;
                w_rf_data = w_head.data;
            end else if (w_bypass) begin
                w_rf_we   = 1'b1;
                w_rf_reg  = bus.MDU_WriteReg;
                w_rf_data = bus.MDU_WriteData;
            end
        end
    end

    always_comb begin
        w_count_nxt = w_count;
        if (w_enq && !w_pop)
            w_count_nxt = w_count + (PTR_W+1)'(1);
        else if (!w_enq && w_pop)
            w_count_nxt = w_count - (PTR_W+1)'(1);
    end

    always_comb begin
        w_starve_nxt = r_starve;
        w_state_nxt  = r_state;
        if (w_pop || w_count == '0)
            w_starve_nxt = '0;
        else if (r_starve != STARVE_MAX)
            w_starve_nxt = r_starve + SC_W'(1);
        // Head has waited its limit and still lost the port: steal the next slot.
        if (w_count != '0 && !w_pop && r_starve == STARVE_MAX)
            w_state_nxt = FORCE;
        else if (w_count_nxt != '0)
            w_state_nxt = PENDING;
        else
            w_state_nxt = IDLE;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    assign bus.MDU_Ready     = w_ready;
    assign bus.RF_RegWrite   = w_rf_we;
    assign bus.RF_WriteReg   = w_rf_reg;
    assign bus.RF_WriteData  = w_rf_data;
    assign bus.WB_Stall      = w_stall;
    assign bus.Pending_Count = w_count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (default build) with a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int LIMIT = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    wb_port_arbiter_if #(.PTR_W(2)) bus ();

    wb_port_arbiter #(.DEPTH(DEPTH), .PTR_W(2), .STARVE_LIMIT(LIMIT)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_rf(input string nm, input logic [4:0] r, input logic [31:0] d);
        chk({nm, "_we"},   32'(bus.RF_RegWrite), 32'd1);
        chk({nm, "_reg"},  32'(bus.RF_WriteReg), 32'(r));
        chk({nm, "_data"}, bus.RF_WriteData, d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic we, input logic [4:0] r, input logic [31:0] d);
        bus.WB_RegWrite  = we;
        bus.WB_WriteReg  = r;
        bus.WB_WriteData = d;
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        bus.MDU_Valid     = 1'b1;
        bus.MDU_WriteReg  = r;
        bus.MDU_WriteData = d;
    endtask

    // Reference: a queue of pending {reg,data}, how long the head side has gone
    // undrained, and whether this cycle is a stolen (stall) slot.
    logic [36:0] mq[$];
    int          m_wait;
    bit          m_force;
    bit          m_pipe, m_pop, m_we, m_hit, m_nforce, m_acc;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    int          m_sz;

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            m_wait  = 0;
            m_force = 0;
        end else begin
            m_pipe = bus.WB_RegWrite && (bus.WB_WriteReg != 5'd0);
            m_sz   = mq.size();
            m_we = 0; m_reg = 0; m_data = 0; m_pop = 0;
            if (m_force) begin
                m_we = 1; m_pop = 1; {m_reg, m_data} = mq[0];
            end else if (m_pipe) begin
                m_we = 1; m_reg = bus.WB_WriteReg; m_data = bus.WB_WriteData;
            end else if (m_sz > 0) begin
                m_we = 1; m_pop = 1; {m_reg, m_data} = mq[0];
            end
            m_hit = 0;
            foreach (mq[i]) if (bus.Query_Reg != 5'd0 && mq[i][36:32] == bus.Query_Reg) m_hit = 1;
            chk("m_rf_we",   32'(bus.RF_RegWrite),   32'(m_we));
            chk("m_rf_reg",  32'(bus.RF_WriteReg),   32'(m_reg));
            chk("m_rf_data", bus.RF_WriteData,       m_data);
            chk("m_stall",   32'(bus.WB_Stall),      32'(m_force));
            chk("m_ready",   32'(bus.MDU_Ready),     32'(m_sz < DEPTH));
            chk("m_pending", 32'(bus.Pending_Count), 32'(m_sz));
            chk("m_qhit",    32'(bus.Query_Hit),     32'(m_hit));
            m_acc    = bus.MDU_Valid && (m_sz < DEPTH) && (bus.MDU_WriteReg != 5'd0);
            m_nforce = !m_pop && m_sz > 0 && m_wait == LIMIT - 1;
            m_wait   = (m_pop || m_sz == 0) ? 0 : m_wait + 1;
            if (m_pop) void'(mq.pop_front());
            if (m_acc) mq.push_back({bus.MDU_WriteReg, bus.MDU_WriteData});
            m_force  = m_nforce;
        end
    end

    initial begin
        rst = 1'b1;
        pipe(1'b0, 5'd0, 32'd0);
        bus.MDU_Valid = 1'b0; bus.MDU_WriteReg = 5'd0; bus.MDU_WriteData = 32'd0;
        bus.Query_Reg = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we",      32'(bus.RF_RegWrite),   32'd0);
        chk("rst_stall",   32'(bus.WB_Stall),      32'd0);
        chk("rst_ready",   32'(bus.MDU_Ready),     32'd1);
        chk("rst_pending", 32'(bus.Pending_Count), 32'd0);
        chk("rst_qhit",    32'(bus.Query_Hit),     32'd0);
        rst = 1'b0;

        // In-order drain with an idle pipeline, one cycle behind each push.
        push(5'd3, 32'h11); #2; chk("drain0_we", 32'(bus.RF_RegWrite), 32'd0);
        tick; push(5'd4, 32'h22); #2; chk_rf("drain1", 5'd3, 32'h11);
        chk("drain1_cnt", 32'(bus.Pending_Count), 32'd1);
        tick; push(5'd5, 32'h33); #2; chk_rf("drain2", 5'd4, 32'h22);
        tick; bus.MDU_Valid = 1'b0; #2; chk_rf("drain3", 5'd5, 32'h33);
        tick; #2;
        chk("drain4_we",  32'(bus.RF_RegWrite),   32'd0);
        chk("drain4_cnt", 32'(bus.Pending_Count), 32'd0);

        // Scoreboard query and pipeline write to $0 freeing the slot.
        tick; pipe(1'b1, 5'd8, 32'hAAAA); push(5'd7, 32'h77); #2; chk_rf("sb0", 5'd8, 32'hAAAA);
        tick; bus.MDU_Valid = 1'b0; bus.Query_Reg = 5'd7; #2;
        chk("sb_hit", 32'(bus.Query_Hit), 32'd1);
        chk("sb_cnt", 32'(bus.Pending_Count), 32'd1);
        bus.Query_Reg = 5'd0; #1; chk("sb_q0", 32'(bus.Query_Hit), 32'd0);
        tick; bus.WB_WriteReg = 5'd0; bus.Query_Reg = 5'd7; #2;
        chk_rf("zero_drain", 5'd7, 32'h77);
        chk("sb_hit_pop", 32'(bus.Query_Hit), 32'd1);
        tick; #2;
        chk("sb_after", 32'(bus.Query_Hit), 32'd0);
        chk("zero_no_fwd", 32'(bus.RF_RegWrite), 32'd0);
        tick; pipe(1'b0, 5'd0, 32'd0); bus.Query_Reg = 5'd0; push(5'd0, 32'h99); #2;
        chk("z_ready", 32'(bus.MDU_Ready), 32'd1);
        tick; bus.MDU_Valid = 1'b0; #2;
        chk("z_cnt", 32'(bus.Pending_Count), 32'd0);
        chk("z_we",  32'(bus.RF_RegWrite),   32'd0);

        // Starvation: 8 pipeline writes, one stolen stall slot, then pipeline again.
        tick; pipe(1'b1, 5'd8, 32'hDEAD); push(5'd9, 32'h1234); #2; chk_rf("st0", 5'd8, 32'hDEAD);
        tick; bus.MDU_Valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            #2; chk_rf("st_pipe", 5'd8, 32'hDEAD); chk("st_nostall", 32'(bus.WB_Stall), 32'd0);
            tick;
        end
        #2; chk("st_force", 32'(bus.WB_Stall), 32'd1); chk_rf("st_force", 5'd9, 32'h1234);
        tick; #2; chk_rf("st_resume", 5'd8, 32'hDEAD);
        chk("st_resume_stall", 32'(bus.WB_Stall), 32'd0);
        chk("st_resume_cnt", 32'(bus.Pending_Count), 32'd0);

        // Full: four buffered entries, fifth request waits for the cycle after a pop.
        tick;
        for (int i = 0; i < 4; i++) begin
            push(5'(10 + i), 32'(32'h100 + i)); tick;
        end
        push(5'd14, 32'h14E); #2;
        chk("full_cnt",   32'(bus.Pending_Count), 32'd4);
        chk("full_ready", 32'(bus.MDU_Ready),     32'd0);
        tick; pipe(1'b0, 5'd0, 32'd0); #2;
        chk("full_pop_ready", 32'(bus.MDU_Ready), 32'd0); chk_rf("full_f5", 5'd10, 32'h100);
        tick; #2; chk("full_ready_again", 32'(bus.MDU_Ready), 32'd1); chk_rf("full_f6", 5'd11, 32'h101);
        tick; bus.MDU_Valid = 1'b0; #2;
        chk("full_f7_cnt", 32'(bus.Pending_Count), 32'd3); chk_rf("full_f7", 5'd12, 32'h102);
        tick; #2; chk_rf("full_f8", 5'd13, 32'h103);
        tick; #2; chk_rf("full_f9", 5'd14, 32'h14E);
        tick; #2; chk("full_empty", 32'(bus.Pending_Count), 32'd0);

        // Asynchronous reset with three entries pending.
        tick; pipe(1'b1, 5'd8, 32'hBEEF); push(5'd20, 32'd1);
        tick; push(5'd21, 32'd2);
        tick; push(5'd22, 32'd3);
        tick; bus.MDU_Valid = 1'b0; bus.Query_Reg = 5'd21; #2;
        chk("mr_cnt", 32'(bus.Pending_Count), 32'd3);
        chk("mr_hit", 32'(bus.Query_Hit), 32'd1);
        rst = 1'b1; #1;
        chk("mr_rst_cnt",   32'(bus.Pending_Count), 32'd0);
        chk("mr_rst_we",    32'(bus.RF_RegWrite),   32'd0);
        chk("mr_rst_ready", 32'(bus.MDU_Ready),     32'd1);
        chk("mr_rst_hit",   32'(bus.Query_Hit),     32'd0);
        chk("mr_rst_stall", 32'(bus.WB_Stall),      32'd0);
        tick; tick; rst = 1'b0; pipe(1'b0, 5'd0, 32'd0); bus.Query_Reg = 5'd0;
        tick; #2;
        chk("mr_post_cnt", 32'(bus.Pending_Count), 32'd0);
        chk("mr_post_we",  32'(bus.RF_RegWrite),   32'd0);

        tick;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
